// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - RISC-V opcode constants recognised by the predecoder
//   - fetch FSM state encoding
//   - instruction-queue entry layout
//   - predecode helper: prediction and next PC for one fetched word
package ifetch_unit_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } iq_entry_t;

  typedef struct packed {
    logic        pred;
    logic [31:0] next_pc;
  } predecode_t;

  // Conditional branches follow the BHT, JAL is always taken, everything
  // else falls through. Adds wrap modulo 2^32.
  function automatic predecode_t predecode(input logic [31:0] inst,
                                           input logic [31:0] pc,
                                           input logic        bht_taken);
    predecode_t  r;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    r.pred    = 1'b0;
    r.next_pc = pc + 32'd4;
    if (inst[6:0] == OPC_BRANCH) begin
      r.pred = bht_taken;
      if (bht_taken) r.next_pc = pc + imm_b;
    end else if (inst[6:0] == OPC_JAL) begin
      r.pred    = 1'b1;
      r.next_pc = pc + imm_j;
    end
    return r;
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Circular instruction queue between fetch and decode.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   rdy            global enable; 0 freezes pointers, count and storage
//   push/push_data enqueue one entry (ignored when full)
//   pop            dequeue the head entry (ignored when empty)
//   flush          discard all entries; wins over push and pop
//   head           current head entry (valid when !empty)
//   full, empty    occupancy flags
module ifetch_queue
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned IQ_DEPTH_LOG = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      push,
  input  iq_entry_t push_data,
  input  logic      pop,
  input  logic      flush,
  output iq_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned DEPTH = 1 << IQ_DEPTH_LOG;
  localparam logic [IQ_DEPTH_LOG-1:0] PTR_ONE = 1;
  localparam logic [IQ_DEPTH_LOG:0]   CNT_ONE = 1;

  iq_entry_t               mem [DEPTH];
  logic [IQ_DEPTH_LOG-1:0] head_q;
  logic [IQ_DEPTH_LOG-1:0] tail_q;
  logic [IQ_DEPTH_LOG:0]   count_q;
  logic                    do_push;
  logic                    do_pop;

  // count never exceeds DEPTH, so its MSB alone marks the full condition
  assign full    = count_q[IQ_DEPTH_LOG];
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[head_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (do_push) tail_q <= tail_q + PTR_ONE;
        if (do_pop)  head_q <= head_q + PTR_ONE;
        if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
        else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && do_push) mem[tail_q] <= push_data;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: keeps the PC, runs one outstanding icache request
// at a time, predecodes returned words (BHT lookup for branches, JAL target
// computation) and queues {inst, pc, pred} for the decoder. ROB redirects
// flush the queue and restart fetch at the new PC.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rdy                           global enable; 0 freezes all state
//   icache_req/icache_addr        fetch request, held until icache_valid
//   icache_valid/icache_inst      one-cycle response strobe and data
//   bht_id/bht_taken              BHT index of the in-flight fetch, prediction
//   dec_valid/dec_ready           queue head handshake with the decoder
//   dec_inst/dec_pc/dec_pred_taken  queue head contents
//   rob_redirect/rob_redirect_pc  flush pulse and restart PC
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned IQ_DEPTH_LOG = 3,
  parameter int unsigned BHT_IDX_W    = 12,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_inst,
  output logic [31:0] bht_id,
  input  logic        bht_taken,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        dec_pred_taken,
  input  logic        rob_redirect,
  input  logic [31:0] rob_redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  // Address of the request on the bus; kept separately from pc so a redirect
  // during DROP can move pc while the abandoned request stays stable.
  logic [31:0]  fetch_addr_q, fetch_addr_d;

  predecode_t   pd;
  iq_entry_t    push_entry;
  iq_entry_t    head_entry;
  logic         q_push;
  logic         q_pop;
  logic         q_flush;
  logic         q_full;
  logic         q_empty;

  assign pd         = predecode(icache_inst, pc_q, bht_taken);
  assign push_entry = '{inst: icache_inst, pc: pc_q, pred: pd.pred};

  assign icache_req  = (state_q == FS_WAIT) || (state_q == FS_DROP);
  assign icache_addr = fetch_addr_q;
  assign bht_id      = 32'(fetch_addr_q[BHT_IDX_W+1:2]);

  assign dec_valid      = ~q_empty & ~rob_redirect;
  assign dec_inst       = head_entry.inst;
  assign dec_pc         = head_entry.pc;
  assign dec_pred_taken = head_entry.pred;
  assign q_pop          = dec_valid & dec_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    q_push       = 1'b0;
    q_flush      = 1'b0;
    if (rob_redirect) begin
      // Redirect outranks everything; an in-flight request must still be
      // drained, so WAIT without a response turns into DROP.
      q_flush = 1'b1;
      pc_d    = rob_redirect_pc;
      case (state_q)
        FS_WAIT: state_d = icache_valid ? FS_IDLE : FS_DROP;
        FS_DROP: if (icache_valid) state_d = FS_IDLE;
        default: state_d = FS_IDLE;
      endcase
    end else begin
      case (state_q)
        FS_IDLE: begin
          // Enter WAIT only with a free slot, which the response will use.
          if (!q_full) begin
            state_d      = FS_WAIT;
            fetch_addr_d = pc_q;
          end
        end
        FS_WAIT: begin
          if (icache_valid) begin
            q_push  = 1'b1;
            pc_d    = pd.next_pc;
            state_d = FS_IDLE;
          end
        end
        FS_DROP: begin
          if (icache_valid) state_d = FS_IDLE;
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FS_IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  ifetch_queue #(
    .IQ_DEPTH_LOG(IQ_DEPTH_LOG)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .push      (q_push),
    .push_data (push_entry),
    .pop       (q_pop),
    .flush     (q_flush),
    .head      (head_entry),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid = 1'b0;
  logic [31:0] icache_inst = '0;
  logic [31:0] bht_id;
  logic        bht_taken = 1'b0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_pred_taken;
  logic        rob_redirect = 1'b0;
  logic [31:0] rob_redirect_pc = '0;

  int n_checks = 0;
  int n_fail   = 0;
  iq_entry_t exp_q[$];

  ifetch_unit #(
    .IQ_DEPTH_LOG(3),
    .BHT_IDX_W(12),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_valid(icache_valid), .icache_inst(icache_inst),
    .bht_id(bht_id), .bht_taken(bht_taken),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_pred_taken(dec_pred_taken),
    .rob_redirect(rob_redirect), .rob_redirect_pc(rob_redirect_pc)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every accepted head is matched against the oldest
  // expected entry; an accepted head with nothing expected is an error.
  always @(negedge clk) begin
    if (!rst && rdy && dec_valid && dec_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dec_unexpected: got inst=%h pc=%h pred=%b, required no entry",
                 dec_inst, dec_pc, dec_pred_taken);
      end else begin
        iq_entry_t e;
        e = exp_q.pop_front();
        if ({dec_inst, dec_pc, dec_pred_taken} !== {e.inst, e.pc, e.pred}) begin
          n_fail++;
          $display("FAIL dec_entry: got inst=%h pc=%h pred=%b, required inst=%h pc=%h pred=%b",
                   dec_inst, dec_pc, dec_pred_taken, e.inst, e.pc, e.pred);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (icache_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: icache_req=0 after 50 cycles, required 1");
    end
  endtask

  // Answer the pending request; returns the address and BHT index observed
  // in the response cycle so callers can compare them.
  task automatic serve(input logic [31:0] inst, input logic bht, input logic [31:0] exp_pc,
                       input logic exp_pred, output logic [31:0] got_addr,
                       output logic [31:0] got_bht_id);
    wait_req();
    got_addr     = icache_addr;
    got_bht_id   = bht_id;
    icache_valid = 1'b1;
    icache_inst  = inst;
    bht_taken    = bht;
    exp_q.push_back('{inst: inst, pc: exp_pc, pred: exp_pred});
    tick();
    icache_valid = 1'b0;
    bht_taken    = 1'b0;
  endtask

  // Redirect coinciding with the response: word discarded, fetch restarts.
  task automatic set_pc(input logic [31:0] new_pc);
    wait_req();
    rob_redirect    = 1'b1;
    rob_redirect_pc = new_pc;
    icache_valid    = 1'b1;
    icache_inst     = 32'h00000013;
    tick();
    rob_redirect = 1'b0;
    icache_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++; if (icache_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, required 0", icache_req); end
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %b, required 0", dec_valid); end
    n_checks++; if (bht_id !== 32'h0) begin n_fail++; $display("FAIL reset_bht_id: got %h, required 0", bht_id); end
    rst = 1'b0;
    tick();
    n_checks++; if (icache_req !== 1'b1) begin n_fail++; $display("FAIL reset_first_req: got %b, required 1", icache_req); end
    n_checks++; if (icache_addr !== 32'h0) begin n_fail++; $display("FAIL reset_first_addr: got %h, required 00000000", icache_addr); end
  endtask

  task automatic test_addi();
    logic [31:0] a, b;
    serve(32'h00100093, 1'b0, 32'h0, 1'b0, a, b);
    n_checks++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL addi_visible: dec_valid got %b, required 1", dec_valid); end
    wait_req();
    n_checks++; if (icache_addr !== 32'h4) begin n_fail++; $display("FAIL addi_next_addr: got %h, required 00000004", icache_addr); end
  endtask

  task automatic test_branch();
    logic [31:0] a, b;
    set_pc(32'h10);
    serve(32'hFE000EE3, 1'b1, 32'h10, 1'b1, a, b);
    n_checks++; if (a !== 32'h10) begin n_fail++; $display("FAIL br_addr: got %h, required 00000010", a); end
    n_checks++; if (b !== 32'h4) begin n_fail++; $display("FAIL br_bht_id: got %h, required 00000004", b); end
    wait_req();
    n_checks++; if (icache_addr !== 32'h0C) begin n_fail++; $display("FAIL br_taken_next: got %h, required 0000000c", icache_addr); end
    set_pc(32'h10);
    serve(32'hFE000EE3, 1'b0, 32'h10, 1'b0, a, b);
    wait_req();
    n_checks++; if (icache_addr !== 32'h14) begin n_fail++; $display("FAIL br_nt_next: got %h, required 00000014", icache_addr); end
  endtask

  task automatic test_jal();
    logic [31:0] a, b;
    for (int k = 0; k < 2; k++) begin
      set_pc(32'h20);
      serve(32'h0080006F, k[0], 32'h20, 1'b1, a, b);
      wait_req();
      n_checks++; if (icache_addr !== 32'h28) begin n_fail++; $display("FAIL jal_next_%0d: got %h, required 00000028", k, icache_addr); end
    end
  endtask

  task automatic test_full();
    logic [31:0] a, b;
    set_pc(32'h40);
    dec_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      serve(32'h00100093, 1'b0, 32'h40 + 32'(4 * i), 1'b0, a, b);
      n_checks++; if (a !== 32'h40 + 32'(4 * i)) begin n_fail++; $display("FAIL full_addr_%0d: got %h, required %h", i, a, 32'h40 + 32'(4 * i)); end
    end
    n_checks++; if ({dec_valid, dec_pc} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL full_head: got valid=%b pc=%h, required valid=1 pc=00000040", dec_valid, dec_pc); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (icache_req !== 1'b0) begin n_fail++; $display("FAIL full_no_req_%0d: got %b, required 0", i, icache_req); end
      tick();
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    wait_req();
    n_checks++; if (icache_addr !== 32'h60) begin n_fail++; $display("FAIL full_resume_addr: got %h, required 00000060", icache_addr); end
    dec_ready = 1'b1;
    repeat (10) tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    logic [31:0] a, b;
    // Pending request at 0x60; redirect without a response -> DROP.
    rob_redirect = 1'b1; rob_redirect_pc = 32'h100;
    tick();
    rob_redirect = 1'b0;
    n_checks++; if ({icache_req, icache_addr} !== {1'b1, 32'h60}) begin n_fail++; $display("FAIL drop_hold: got req=%b addr=%h, required req=1 addr=00000060", icache_req, icache_addr); end
    tick();
    icache_valid = 1'b1; icache_inst = 32'h00100093;
    tick();
    icache_valid = 1'b0;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL drop_discard: dec_valid got %b, required 0", dec_valid); end
    wait_req();
    n_checks++; if (icache_addr !== 32'h100) begin n_fail++; $display("FAIL drop_next_addr: got %h, required 00000100", icache_addr); end
    // Redirect and response in the same cycle.
    rob_redirect = 1'b1; rob_redirect_pc = 32'h200; icache_valid = 1'b1;
    tick();
    rob_redirect = 1'b0; icache_valid = 1'b0;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL same_cycle_discard: dec_valid got %b, required 0", dec_valid); end
    wait_req();
    n_checks++; if (icache_addr !== 32'h200) begin n_fail++; $display("FAIL same_cycle_next: got %h, required 00000200", icache_addr); end
    serve(32'h00100093, 1'b0, 32'h200, 1'b0, a, b);
    // Second redirect while already dropping: last target wins.
    wait_req();
    rob_redirect = 1'b1; rob_redirect_pc = 32'h300;
    tick();
    rob_redirect_pc = 32'h400;
    tick();
    rob_redirect = 1'b0;
    n_checks++; if ({icache_req, icache_addr} !== {1'b1, 32'h204}) begin n_fail++; $display("FAIL drop_redirect_hold: got req=%b addr=%h, required req=1 addr=00000204", icache_req, icache_addr); end
    icache_valid = 1'b1;
    tick();
    icache_valid = 1'b0;
    wait_req();
    n_checks++; if (icache_addr !== 32'h400) begin n_fail++; $display("FAIL drop_redirect_next: got %h, required 00000400", icache_addr); end
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] a, b;
    rdy = 1'b0;
    rob_redirect = 1'b1; rob_redirect_pc = 32'h500;
    for (int i = 0; i < 5; i++) begin
      dec_ready = i[0];
      tick();
      n_checks++; if ({icache_req, icache_addr} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL freeze_%0d: got req=%b addr=%h, required req=1 addr=00000400", i, icache_req, icache_addr); end
    end
    rob_redirect = 1'b0; dec_ready = 1'b1; rdy = 1'b1;
    serve(32'h0080006F, 1'b0, 32'h400, 1'b1, a, b);
    wait_req();
    n_checks++; if (icache_addr !== 32'h408) begin n_fail++; $display("FAIL freeze_resume: got %h, required 00000408", icache_addr); end
    // Asynchronous reset in the middle of WAIT.
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_checks++; if ({icache_req, dec_valid, bht_id} !== {1'b0, 1'b0, 32'h0}) begin n_fail++; $display("FAIL async_rst: got req=%b dec_valid=%b bht_id=%h, required 0 0 00000000", icache_req, dec_valid, bht_id); end
    tick();
    rst = 1'b0;
    wait_req();
    n_checks++; if (icache_addr !== 32'h0) begin n_fail++; $display("FAIL rst_restart_addr: got %h, required 00000000", icache_addr); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_jal();
    test_full();
    test_redirect();
    test_rdy_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
